random_pulse_array: RTL and testbench
=====================================

RANDOM_PULSE_ARRAY -- requirements
Module: random_pulse_array

Interface
REQ-001 Parameter NCH, default 4: number of independent pulse channels, 1..16.
REQ-002 Parameter LFSR_W, default 16: LFSR width per channel, one of 8/16/24/32.
REQ-003 Parameter RATE_W, default 8: rate threshold width, at most LFSR_W.
REQ-004 Parameter DT_W, default 8: dead-time counter width.
REQ-005 Parameter CNT_W, default 16: per-channel event counter width.
REQ-006 Parameter SEED, default 16'hACE1 zero-extended to LFSR_W: non-zero base seed.
REQ-007 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-008 Port rst_n, input, 1: asynchronous active-low reset.
REQ-009 Port en, input, 1: global run enable.
REQ-010 Port rate, input, RATE_W: per-cycle hit threshold, shared by all channels.
REQ-011 Port dead_time, input, DT_W: non-paralyzable dead time in cycles.
REQ-012 Port clr_cnt, input, 1: synchronous clear of all event counters.
REQ-013 Port pulse, output, NCH: registered one-cycle pulse per channel.
REQ-014 Port any_pulse, output, 1: OR of pulse[NCH-1:0].
REQ-015 Port event_cnt, output, NCH*CNT_W: channel i count in bits [i*CNT_W +: CNT_W].

Function
REQ-016 Channel i LFSR shall reset to SEED rotated left by i bits; it is never zero.
REQ-017 Each LFSR shall be a maximal-length Fibonacci shift-left register (new LSB = XOR of package taps) advancing once per cycle while en=1 and holding while en=0.
REQ-018 For LFSR_W=16 the feedback shall be lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
REQ-019 Channel hit shall be en=1 AND lfsr[RATE_W-1:0] < rate (unsigned, current register value).
REQ-020 rate=0 shall produce no hits; hit probability per cycle is rate/2^RATE_W.
REQ-021 pulse[i] shall assert for exactly one cycle, on the cycle after a hit, if channel i dead counter is zero when the hit occurs.
REQ-022 On a pulse edge, the dead counter shall load dead_time (sampled at that edge); otherwise it decrements by 1 when non-zero, regardless of en.
REQ-023 Hits while the dead counter is non-zero shall be dropped without extending dead time (non-paralyzable).
REQ-024 Minimum spacing between pulse[i] rising edges shall be dead_time+1 cycles; dead_time=0 permits a pulse on every cycle.
REQ-025 en=0 shall force pulse to 0 from the next cycle; counters and dead counters are retained.
REQ-026 event_cnt[i] shall increment on the edge at which pulse[i] is set, saturating at all-ones with no wrap.
REQ-027 clr_cnt=1 shall zero all event counters at the next edge; clear wins over a simultaneous increment.
REQ-028 any_pulse shall be combinational OR of the registered pulse vector (no added latency).

Reset
REQ-029 rst_n low shall asynchronously set pulse=0, any_pulse=0, event_cnt=0, dead counters=0 and LFSRs to REQ-016 seeds.
REQ-030 Reset asserted mid-dead-time or mid-pulse shall abort immediately; first post-reset hit is evaluated on the first edge after release.

Structure
REQ-031 Package rpg_pkg shall hold tap-mask constants for 8/16/24/32-bit maximal LFSRs and the default SEED.
REQ-032 Sub-module rpg_lfsr (parameters WIDTH, SEED; ports clk, rst_n, adv, q) shall be instantiated NCH times via generate.
REQ-033 Dead-time, hit compare and counter logic shall reside in a per-channel generate block in random_pulse_array.

Verification
REQ-034 Reset release, NCH=4, LFSR_W=16: channel 0 LFSR = 16'hACE1, channel 1 = 16'h59C3; next-cycle channel 0 = 16'h59C3 (seed shifted, feedback 1).
REQ-035 en=1, rate=0, 10000 cycles -> pulse never asserted, event_cnt all 0.
REQ-036 rate=8'hFF, dead_time=3 -> no two pulse[i] edges closer than 4 cycles; rate=8'hFF, dead_time=0 -> pulses on >=99% of cycles.
REQ-037 rate=8'h40, dead_time=0, 2^16 cycles -> each event_cnt within 16384 +/- 2%, channels pairwise not identical.
REQ-038 CNT_W=4, rate=8'hFF, dead_time=0 -> event_cnt saturates at 15; clr_cnt coinciding with a pulse -> count reads 0 next cycle.
REQ-039 rst_n asserted asynchronously mid-dead-time -> pulse and counters 0 immediately, LFSR seeds restored, no pulse on the release edge.

Source files
------------

// File: rtl/rpg_pkg.sv
// Shared constants for the random pulse array: maximal-length LFSR tap masks
// and the default non-zero seed.
package rpg_pkg;

  // Bit positions (0-based) XORed into the new LSB of a shift-left Fibonacci LFSR.
  localparam logic [31:0] TAPS_8       = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16      = 32'h0000_B400;
  localparam logic [31:0] TAPS_24      = 32'h00E1_0000;
  localparam logic [31:0] TAPS_32      = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      8:       taps = TAPS_8;
      24:      taps = TAPS_24;
      32:      taps = TAPS_32;
      default: taps = TAPS_16;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/rpg_lfsr.sv
// Maximal-length Fibonacci LFSR, shift-left, new LSB from the package taps.
// Advances only when adv is high; resets to SEED, which must be non-zero.
module rpg_lfsr
  import rpg_pkg::*;
#(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     SEED  = DEFAULT_SEED[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             w_fb;

  assign w_fb = ^(r_q & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (adv) begin
      r_q <= {r_q[WIDTH-2:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/random_pulse_array.sv
// Array of independent LFSR-driven random pulse generators with non-paralyzable
// dead time and saturating per-channel event counters.
module random_pulse_array
  import rpg_pkg::*;
#(
  parameter int unsigned        NCH    = 4,
  parameter int unsigned        LFSR_W = 16,
  parameter int unsigned        RATE_W = 8,
  parameter int unsigned        DT_W   = 8,
  parameter int unsigned        CNT_W  = 16,
  parameter logic [LFSR_W-1:0]  SEED   = DEFAULT_SEED[LFSR_W-1:0]
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [RATE_W-1:0]    rate,
  input  logic [DT_W-1:0]      dead_time,
  input  logic                 clr_cnt,
  output logic [NCH-1:0]       pulse,
  output logic                 any_pulse,
  output logic [NCH*CNT_W-1:0] event_cnt
);

  function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] v, input int n);
    logic [LFSR_W-1:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      r = {r[LFSR_W-2:0], r[LFSR_W-1]};
    end
    return r;
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Rotating the seed per channel decorrelates the channels' phases.
    localparam logic [LFSR_W-1:0] CH_SEED = rotl(SEED, i);

    logic [LFSR_W-1:0] w_lfsr;
    logic              w_hit;
    logic              w_fire;
    logic              r_pulse;
    logic [DT_W-1:0]   r_dead;
    logic [CNT_W-1:0]  r_cnt;

    rpg_lfsr #(
      .WIDTH (LFSR_W),
      .SEED  (CH_SEED)
    ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (en),
      .q     (w_lfsr)
    );

    if (RATE_W < LFSR_W) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_lfsr[LFSR_W-1:RATE_W];
    end

    assign w_hit  = en && (w_lfsr[RATE_W-1:0] < rate);
    assign w_fire = w_hit && (r_dead == '0);

    // Hits during dead time are dropped and never reload the counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pulse <= 1'b0;
        r_dead  <= '0;
        r_cnt   <= '0;
      end else begin
        r_pulse <= w_fire;
        if (w_fire) begin
          r_dead <= dead_time;
        end else if (r_dead != '0) begin
          r_dead <= r_dead - 1'b1;
        end
        if (clr_cnt) begin
          r_cnt <= '0;
        end else if (w_fire && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign pulse[i]                     = r_pulse;
    assign event_cnt[i*CNT_W +: CNT_W]  = r_cnt;
  end

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_random_pulse_array.sv
// Scoreboard bench for random_pulse_array: a reference model predicts pulses
// and counts for a 16-bit-counter and a 4-bit-counter instance every cycle.
module tb_random_pulse_array;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 en = 1'b0;
  logic                 clr_cnt = 1'b0;
  logic [7:0]           rate = 8'h00;
  logic [7:0]           dead_time = 8'h00;
  logic [NCH-1:0]       pulse, pulse_s;
  logic                 any_pulse, any_pulse_s;
  logic [NCH*CW-1:0]    event_cnt;
  logic [NCH*CWS-1:0]   event_cnt_s;

  always #5 clk = ~clk;

  random_pulse_array #(.NCH(NCH), .LFSR_W(16), .RATE_W(8), .DT_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rate(rate), .dead_time(dead_time),
    .clr_cnt(clr_cnt), .pulse(pulse), .any_pulse(any_pulse), .event_cnt(event_cnt));

  random_pulse_array #(.NCH(NCH), .LFSR_W(16), .RATE_W(8), .DT_W(8), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .rate(rate), .dead_time(dead_time),
    .clr_cnt(clr_cnt), .pulse(pulse_s), .any_pulse(any_pulse_s), .event_cnt(event_cnt_s));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [15:0]    m_lfsr [NCH];
  int             m_dead [NCH];
  logic [NCH-1:0] m_pulse;
  logic [15:0]    m_cnt  [NCH];
  logic [3:0]     m_cnts [NCH];

  typedef struct packed {
    logic [NCH-1:0]      pulse;
    logic [NCH*CW-1:0]   cnt;
    logic [NCH*CWS-1:0]  cnts;
  } exp_t;
  exp_t sb[$];

  // Observed-behaviour statistics
  int cyc;
  int last_p [NCH];
  int min_gap[NCH];
  int npulse [NCH];
  bit differ [NCH][NCH];

  function automatic logic [15:0] seed_of(input int ch);
    logic [15:0] s;
    s = 16'hACE1;
    for (int k = 0; k < ch; k++) s = {s[14:0], s[15]};
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_lfsr[i] = seed_of(i);
      m_dead[i] = 0;
      m_cnt[i]  = '0;
      m_cnts[i] = '0;
    end
    m_pulse = '0;
  endtask

  task automatic clear_stats();
    cyc = 0;
    for (int i = 0; i < NCH; i++) begin
      last_p[i]  = -1000000;
      min_gap[i] = 1000000;
      npulse[i]  = 0;
      for (int j = 0; j < NCH; j++) differ[i][j] = 1'b0;
    end
  endtask

  // Predict one clock edge from the current inputs, then compare after it.
  task automatic step();
    exp_t e;
    exp_t got;
    for (int i = 0; i < NCH; i++) begin
      logic fire;
      fire = en && (m_lfsr[i][7:0] < rate) && (m_dead[i] == 0);
      m_pulse[i] = fire;
      if (fire) m_dead[i] = int'(dead_time);
      else if (m_dead[i] > 0) m_dead[i] = m_dead[i] - 1;
      if (clr_cnt) begin
        m_cnt[i] = '0; m_cnts[i] = '0;
      end else if (fire) begin
        if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
        if (m_cnts[i] != 4'hF)    m_cnts[i] = m_cnts[i] + 4'd1;
      end
      if (en) m_lfsr[i] = {m_lfsr[i][14:0],
                           m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
      e.cnt[i*CW +: CW]    = m_cnt[i];
      e.cnts[i*CWS +: CWS] = m_cnts[i];
    end
    e.pulse = m_pulse;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("pulse",       64'(pulse),       64'(got.pulse));
    chk("any_pulse",   64'(any_pulse),   64'(|got.pulse));
    chk("event_cnt",   64'(event_cnt),   64'(got.cnt));
    chk("pulse_s",     64'(pulse_s),     64'(got.pulse));
    chk("event_cnt_s", 64'(event_cnt_s), 64'(got.cnts));
    for (int i = 0; i < NCH; i++) begin
      if (pulse[i]) begin
        npulse[i]++;
        if (cyc - last_p[i] < min_gap[i]) min_gap[i] = cyc - last_p[i];
        last_p[i] = cyc;
      end
      for (int j = 0; j < NCH; j++)
        if (pulse[i] != pulse[j]) differ[i][j] = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int found;
    model_reset();
    clear_stats();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pulse", 64'(pulse), 64'd0);
    chk("rst_any",   64'(any_pulse), 64'd0);
    chk("rst_cnt",   64'(event_cnt), 64'd0);
    chk("seed_ch0",  64'(dut.g_ch[0].u_lfsr.q), 64'h ACE1);
    chk("seed_ch1",  64'(dut.g_ch[1].u_lfsr.q), 64'h59C3);
    chk("seed_ch3",  64'(dut.g_ch[3].u_lfsr.q), 64'(seed_of(3)));
    @(negedge clk);
    rst_n = 1'b1;

    // First advance of channel 0 and the rate=0 soak
    en = 1'b1; rate = 8'h00; dead_time = 8'd0;
    step();
    chk("lfsr0_adv", 64'(dut.g_ch[0].u_lfsr.q), 64'h59C3);
    repeat (9999) step();
    for (int i = 0; i < NCH; i++) chk("rate0_npulse", 64'(npulse[i]), 64'd0);
    chk("rate0_cnt", 64'(event_cnt), 64'd0);

    // Full rate with dead time 3
    rate = 8'hFF; dead_time = 8'd3;
    clear_stats();
    repeat (2000) step();
    for (int i = 0; i < NCH; i++) begin
      chk("dt3_min_gap", 64'(min_gap[i] >= 4), 64'd1);
      chk("dt3_active",  64'(npulse[i] >= 450), 64'd1);
    end

    // Full rate, no dead time
    dead_time = 8'd0;
    repeat (4) step();
    clear_stats();
    repeat (1000) step();
    for (int i = 0; i < NCH; i++) begin
      chk("dt0_density", 64'(npulse[i] >= 990), 64'd1);
      chk("sat15", 64'(event_cnt_s[i*CWS +: CWS]), 64'd15);
    end

    // Clear coinciding with a pulse edge
    clr_cnt = 1'b1;
    step();
    chk("clr_with_pulse", 64'(pulse[0]), 64'd1);
    chk("clr_wins_s", 64'(event_cnt_s[0 +: CWS]), 64'd0);
    chk("clr_wins",   64'(event_cnt[0 +: CW]), 64'd0);

    // Statistical rate over one LFSR period
    rate = 8'h40;
    step();
    clr_cnt = 1'b0;
    clear_stats();
    repeat (65536) step();
    for (int i = 0; i < NCH; i++) begin
      chk("rate40_lo", 64'(event_cnt[i*CW +: CW] >= 16'd16057), 64'd1);
      chk("rate40_hi", 64'(event_cnt[i*CW +: CW] <= 16'd16711), 64'd1);
      for (int j = i + 1; j < NCH; j++) chk("chan_distinct", 64'(differ[i][j]), 64'd1);
    end

    // Global disable: pulses stop, LFSR holds
    en = 1'b0;
    repeat (5) step();
    chk("en0_hold", 64'(dut.g_ch[0].u_lfsr.q), 64'(m_lfsr[0]));

    // Async reset in the middle of a pulse and a long dead time
    en = 1'b1; rate = 8'hFF; dead_time = 8'd200;
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      step();
      if (pulse[0]) found = 1;
    end
    chk("wait_pulse", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pulse", 64'(pulse), 64'd0);
    chk("arst_any",   64'(any_pulse), 64'd0);
    chk("arst_cnt",   64'(event_cnt), 64'd0);
    chk("arst_cnt_s", 64'(event_cnt_s), 64'd0);
    chk("arst_seed0", 64'(dut.g_ch[0].u_lfsr.q), 64'hACE1);
    chk("arst_seed1", 64'(dut.g_ch[1].u_lfsr.q), 64'h59C3);
    model_reset();
    #1 rst_n = 1'b1;
    #1;
    chk("release_no_pulse", 64'(pulse), 64'd0);
    step();
    chk("first_hit", 64'(pulse[0]), 64'd1);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
